xbar_route_ctrl: RTL and testbench

Control-word sequencer placed directly upstream of the blocking crossbar's control port. It watches the head message of every crossbar input, picks one requesting input round-robin, and decodes its destination from the message header. It issues a single control word routing that input to that output, then holds the grant until PKT_LEN message beats have crossed the crossbar before it arbitrates again.

---
 rtl/xbar_route_ctrl_if.sv | 30 +++
 rtl/xbar_route_ctrl.sv | 116 +++++++++++
 tb/tb_xbar_route_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/xbar_route_ctrl_if.sv
// Request/control bundle between the crossbar inputs, the route sequencer and the crossbar control port.
// master: the sequencer side; slave: the crossbar/requester side.
interface xbar_route_ctrl_if #(
  parameter int unsigned BIT_WIDTH         = 32,
  parameter int unsigned N_INPUTS          = 2,
  parameter int unsigned N_OUTPUTS         = 2,
  parameter int unsigned CONTROL_BIT_WIDTH = 42
);
  localparam int unsigned IW = $clog2(N_INPUTS);

  logic [N_INPUTS-1:0][BIT_WIDTH-1:0] req_msg;
  logic [N_INPUTS-1:0]                req_val;
  logic [N_INPUTS-1:0]                xfer_rdy;
  logic [CONTROL_BIT_WIDTH-1:0]       control;
  logic                               control_val;
  logic                               control_rdy;
  logic                               grant_val;
  logic [IW-1:0]                      grant_idx;
  logic                               err;

  modport master (
    input  req_msg, req_val, xfer_rdy, control_rdy,
    output control, control_val, grant_val, grant_idx, err
  );

  modport slave (
    output req_msg, req_val, xfer_rdy, control_rdy,
    input  control, control_val, grant_val, grant_idx, err
  );
endinterface

// File: rtl/xbar_route_ctrl.sv
// Round-robin control-word sequencer for a blocking crossbar: grants one input,
// issues its route word, then holds the grant for PKT_LEN beats.
module xbar_route_ctrl #(
  parameter int unsigned BIT_WIDTH         = 32,
  parameter int unsigned N_INPUTS          = 2,
  parameter int unsigned N_OUTPUTS         = 2,
  parameter int unsigned CONTROL_BIT_WIDTH = 42,
  parameter int unsigned PKT_LEN           = 4
) (
  input  logic              clk,
  input  logic              reset,
  xbar_route_ctrl_if.master bus
);
  localparam int unsigned IW   = $clog2(N_INPUTS);
  localparam int unsigned OW   = $clog2(N_OUTPUTS);
  localparam int unsigned CW   = CONTROL_BIT_WIDTH;
  localparam int unsigned CNTW = $clog2(PKT_LEN + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   g;
  logic [CW-1:0]   ctrl_word;
  logic [CNTW-1:0] cnt;
  logic            err_q;

  logic            found;
  logic [IW-1:0]   win;
  int unsigned     scan;
  logic [OW-1:0]   dest;
  logic            dest_oob;
  logic [OW-1:0]   sel;
  logic [CW-1:0]   word;
  logic            fire;
  logic            last_beat;
  logic [IW-1:0]   ptr_after;

  // Rotating priority search starting at ptr; first requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = 0;
    for (int unsigned k = 0; k < N_INPUTS; k++) begin
      scan = (32'(ptr) + k) % N_INPUTS;
      if (!found && bus.req_val[IW'(scan)]) begin
        found = 1'b1;
        win   = IW'(scan);
      end
    end
  end

  always_comb begin
    dest     = bus.req_msg[win][BIT_WIDTH-1 -: OW];
    dest_oob = (32'(dest) >= N_OUTPUTS);
    sel      = dest_oob ? OW'(N_OUTPUTS - 1) : dest;
    word     = '0;
    word[CW-1 -: IW]      = win;
    word[CW-1-IW -: OW]   = sel;
  end

  always_comb begin
    fire      = bus.req_val[g] & bus.xfer_rdy[g];
    last_beat = (cnt == CNTW'(PKT_LEN - 1));
    ptr_after = IW'((32'(g) + 1) % N_INPUTS);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = ISSUE;
      ISSUE:   if (bus.control_rdy) state_next = XFER;
      XFER:    if (fire && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      g         <= '0;
      ctrl_word <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (found) begin
            g         <= win;
            ctrl_word <= word;
            err_q     <= err_q | dest_oob;
          end
        end
        ISSUE: begin
          if (bus.control_rdy) cnt <= '0;
        end
        XFER: begin
          if (fire) begin
            cnt <= cnt + CNTW'(1);
            if (last_beat) ptr <= ptr_after;
          end
        end
        default: ;
      endcase
    end
  end

  // The word register is left untouched after XFER: the crossbar keeps its last route.
  assign bus.control     = ctrl_word;
  assign bus.control_val = (state == ISSUE);
  assign bus.grant_val   = (state == XFER);
  assign bus.grant_idx   = g;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_xbar_route_ctrl.sv
// Randomized bench for xbar_route_ctrl with a packet-level reference model.
module tb_xbar_route_ctrl;
  localparam int unsigned BW = 32;
  localparam int unsigned NI = 3;
  localparam int unsigned NO = 3;
  localparam int unsigned CW = 42;
  localparam int unsigned PL = 4;
  localparam int unsigned IW = $clog2(NI);
  localparam int unsigned OW = $clog2(NO);

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  xbar_route_ctrl_if #(.BIT_WIDTH(BW), .N_INPUTS(NI), .N_OUTPUTS(NO),
                       .CONTROL_BIT_WIDTH(CW)) bus ();

  xbar_route_ctrl #(.BIT_WIDTH(BW), .N_INPUTS(NI), .N_OUTPUTS(NO),
                    .CONTROL_BIT_WIDTH(CW), .PKT_LEN(PL)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 waiting, 1 word offered, 2 packet in flight.
  int          m_phase;
  int          m_ptr;
  int          m_g;
  int          m_left;
  bit          m_err;
  logic [CW-1:0] m_word;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int cand;
    int dest;
    int sel;
    logic [31:0] msg;
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_g = 0; m_left = 0; m_err = 0; m_word = '0;
    end else begin
      case (m_phase)
        0: if (bus.req_val != '0) begin
          for (int k = NI - 1; k >= 0; k--) begin
            cand = (m_ptr + k) % NI;
            if (bus.req_val[cand]) m_g = cand;
          end
          msg  = bus.req_msg[m_g];
          dest = int'(msg[31:30]);
          sel  = (dest < NO) ? dest : NO - 1;
          if (dest >= NO) m_err = 1;
          m_word  = (CW'(m_g) << (CW - IW)) | (CW'(sel) << (CW - IW - OW));
          m_phase = 1;
        end
        1: if (bus.control_rdy) begin
          m_phase = 2;
          m_left  = PL;
        end
        default: if (bus.req_val[m_g] && bus.xfer_rdy[m_g]) begin
          m_left--;
          if (m_left == 0) begin
            m_ptr   = (m_g + 1) % NI;
            m_phase = 0;
          end
        end
      endcase
    end
  endtask

  // One clock: DUT and model see the same inputs at the edge; outputs compared at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("control",     64'(bus.control),     64'(m_word));
    check("control_val", 64'(bus.control_val), 64'(m_phase == 1));
    check("grant_val",   64'(bus.grant_val),   64'(m_phase == 2));
    check("grant_idx",   64'(bus.grant_idx),   64'(m_g));
    check("err",         64'(bus.err),         64'(m_err));
  endtask

  int grant_cycles;
  int p_req, p_crdy, p_xrdy;

  initial begin
    reset = 1'b1;
    bus.req_msg = '0; bus.req_val = '0; bus.xfer_rdy = '0; bus.control_rdy = 1'b0;
    m_phase = 0; m_ptr = 0; m_g = 0; m_left = 0; m_err = 0; m_word = '0;
    @(negedge clk);
    repeat (3) step();
    check("reset_control", 64'(bus.control), 64'h0);

    // Single packet from input 1, destination 0.
    reset = 1'b0;
    bus.req_val = 3'b010; bus.xfer_rdy = '1; bus.control_rdy = 1'b1;
    step();
    check("single_word", 64'(bus.control), 64'h100_0000_0000);
    check("single_cval", 64'(bus.control_val), 64'h1);
    grant_cycles = 0;
    repeat (5) begin
      step();
      if (bus.grant_val) grant_cycles++;
    end
    check("single_grant_cycles", 64'(grant_cycles), 64'd4);
    bus.req_val = '0;
    step();
    // Pointer moved past input 1, so input 2 wins when all request.
    bus.req_val = '1;
    bus.req_msg[2] = 32'h8000_0000;
    step();
    check("rr_after_single", 64'(bus.control), 64'h280_0000_0000);
    bus.req_val = '0;
    repeat (8) step();

    for (int blk = 0; blk < 8; blk++) begin
      p_req  = $urandom_range(30, 100);
      p_crdy = $urandom_range(20, 100);
      p_xrdy = $urandom_range(20, 100);
      for (int c = 0; c < 400; c++) begin
        reset = ($urandom_range(0, 199) == 0);
        for (int i = 0; i < NI; i++) begin
          bus.req_val[i]  = ($urandom_range(1, 100) <= p_req);
          bus.xfer_rdy[i] = ($urandom_range(1, 100) <= p_xrdy);
          bus.req_msg[i]  = $urandom;
        end
        bus.control_rdy = ($urandom_range(1, 100) <= p_crdy);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
